// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and hazard_stall_ctrl.
// master: datapath side (drives hazard sources, receives enables/flushes).
// slave:  controller side.
interface hazard_stall_ctrl_if #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
);
   logic [REG_W-1:0] id_rn;
   logic [REG_W-1:0] id_rm;
   logic             id_uses_rn;
   logic             id_uses_rm;
   logic [REG_W-1:0] ex_rd;
   logic             ex_mem_read;
   logic             branch_taken;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             busy;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_mem_read, branch_taken,
      input  pc_en, ifid_en, ifid_flush, idex_flush, busy, stall_count, flush_count
   );

   modport slave (
      input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_mem_read, branch_taken,
      output pc_en, ifid_en, ifid_flush, idex_flush, busy, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// LEGv8 pipeline hazard/stall controller: load-use stall detection and branch-flush
// sequencing for the PC, IF/ID and ID/EX registers.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters;
// without it the counter outputs are tied to zero.
module hazard_stall_ctrl #(
   parameter int unsigned REG_W       = 5,
   parameter int unsigned ZERO_REG    = 31,
   parameter int unsigned FLUSH_EXTRA = 1,
   parameter int unsigned CNT_W       = 16
) (
   input logic               clk,
   input logic               reset,
   hazard_stall_ctrl_if.slave bus
);

   typedef enum logic {StRun, StBrFlush} state_t;

   state_t     r_state;
   state_t     w_state_d;
   logic [3:0] r_rem;
   logic [3:0] w_rem_d;

   logic w_lu;
   logic w_pc_en;
   logic w_ifid_en;
   logic w_ifid_flush;
   logic w_idex_flush;
   logic w_busy;
   logic w_stall_evt;
   logic w_flush_evt;

   // Load-use hazard: a load in EX writes a register the ID instruction actually reads.
   always_comb begin
      w_lu = bus.ex_mem_read && (bus.ex_rd != REG_W'(ZERO_REG)) &&
             ((bus.id_uses_rn && (bus.id_rn == bus.ex_rd)) ||
              (bus.id_uses_rm && (bus.id_rm == bus.ex_rd)));
   end

   // Next-state and control outputs; reset forces a frozen, fully flushed pipeline.
   always_comb begin
      w_state_d    = r_state;
      w_rem_d      = r_rem;
      w_pc_en      = 1'b1;
      w_ifid_en    = 1'b1;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_busy       = 1'b0;
      w_stall_evt  = 1'b0;
      unique case (r_state)
         StRun: begin
            if (bus.branch_taken) begin
               w_ifid_flush = 1'b1;
               w_idex_flush = 1'b1;
               if (FLUSH_EXTRA > 0) begin
                  w_state_d = StBrFlush;
                  w_rem_d   = 4'(FLUSH_EXTRA);
               end
            end else if (w_lu) begin
               // Hold PC and IF/ID, inject one bubble into ID/EX.
               w_pc_en      = 1'b0;
               w_ifid_en    = 1'b0;
               w_idex_flush = 1'b1;
               w_stall_evt  = 1'b1;
            end
         end
         StBrFlush: begin
            // Wrong-path instructions: hazards are irrelevant here.
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_busy       = 1'b1;
            if (bus.branch_taken) begin
               w_rem_d = 4'(FLUSH_EXTRA);
            end else if (r_rem <= 4'd1) begin
               w_state_d = StRun;
               w_rem_d   = 4'd0;
            end else begin
               w_rem_d = r_rem - 4'd1;
            end
         end
         default: begin
            w_state_d = StRun;
            w_rem_d   = 4'd0;
         end
      endcase
      if (reset) begin
         w_pc_en      = 1'b0;
         w_ifid_en    = 1'b0;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
         w_busy       = 1'b0;
         w_stall_evt  = 1'b0;
      end
      w_flush_evt = w_ifid_flush && !reset;
   end

   // State and flush-window counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StRun;
         r_rem   <= 4'd0;
      end else begin
         r_state <= w_state_d;
         r_rem   <= w_rem_d;
      end
   end

   assign bus.pc_en      = w_pc_en;
   assign bus.ifid_en    = w_ifid_en;
   assign bus.ifid_flush = w_ifid_flush;
   assign bus.idex_flush = w_idex_flush;
   assign bus.busy       = w_busy;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating performance counters; they stick at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.stall_count = r_stall_cnt;
   assign bus.flush_count = r_flush_cnt;
`else
   logic w_unused;
   assign w_unused        = w_stall_evt ^ w_flush_evt;
   assign bus.stall_count = '0;
   assign bus.flush_count = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control stage directly upstream of the enable-gated pipeline register bits.
- Generates the per-stage enable (stall) and flush (bubble) signals that drive the enable/d inputs of the PC and IF/ID and ID/EX pipeline registers.
- Detects LEGv8 load-use hazards; sequences branch-flush windows with a small FSM.
- Optionally counts stall and flush cycles for performance measurement.

Parameters:
REG_W, 5, register-index width
ZERO_REG, 31, index of XZR; never a hazard source
FLUSH_EXTRA, 1, extra cycles IF/ID stays flushed after a taken branch (0..15)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
id_rn  input  REG_W  first source register of instruction in ID
id_rm  input  REG_W  second source register of instruction in ID
id_uses_rn  input  1  ID instruction reads id_rn
id_uses_rm  input  1  ID instruction reads id_rm
ex_rd  input  REG_W  destination register of instruction in EX
ex_mem_read  input  1  EX instruction is a load (LDUR)
branch_taken  input  1  taken branch resolved in EX this cycle
pc_en  output  1  PC register enable
ifid_en  output  1  IF/ID register enable
ifid_flush  output  1  force IF/ID contents to bubble (NOP)
idex_flush  output  1  force ID/EX contents to bubble
busy  output  1  FSM is not in RUN
stall_count  output  CNT_W  saturating count of load-use stall cycles
flush_count  output  CNT_W  saturating count of flush cycles

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset).
- While reset is high:
  - pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, busy=0.
  - FSM=RUN, flush counter=0, stall_count=0, flush_count=0.
- Load-use hazard (lu) is:
  - ex_mem_read=1 and ex_rd!=ZERO_REG, and
  - either (id_uses_rn and id_rn==ex_rd) or (id_uses_rm and id_rm==ex_rd).
- FSM states: RUN, BR_FLUSH. A 4-bit down-counter rem holds the remaining flush cycles.
- RUN, branch_taken=1 (takes priority over lu):
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
  - If FLUSH_EXTRA>0: next state BR_FLUSH, rem=FLUSH_EXTRA. Otherwise stay in RUN.
- RUN, lu=1, branch_taken=0:
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1 (one bubble).
  - Stay in RUN. The hazard clears naturally next cycle because EX then holds the bubble.
- RUN, neither: pc_en=1, ifid_en=1, flushes=0.
- BR_FLUSH:
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, busy=1. lu is ignored (wrong-path).
  - rem decrements each cycle; at rem==1 the next state is RUN.
  - A branch_taken arriving in BR_FLUSH reloads rem=FLUSH_EXTRA and stays in BR_FLUSH.
- All outputs except the counters are combinational from state and inputs; zero-cycle latency from hazard to stall.
- Reset asserted mid-flush aborts immediately to RUN. On release, the first cycle is normal RUN evaluation.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count increments on each cycle where lu causes a stall.
  - flush_count increments on each cycle where ifid_flush=1 outside reset.
  - Both saturate at all-ones, with no wrap.
- Undefined: no counter flops; stall_count and flush_count are tied to 0. Ports exist in both builds.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1 that cycle. Next cycle, with ex_mem_read=0 → pc_en=1, no flush. stall_count=1.
- XZR and unused operand:
  - ex_rd=31, id_rn=31, ex_mem_read=1 → no stall.
  - ex_rd=5, id_rm=5, id_uses_rm=0 → no stall.
- Branch, FLUSH_EXTRA=1: branch_taken pulse at cycle T →
  - T: ifid_flush=1, idex_flush=1, busy=0.
  - T+1: busy=1, both flushes=1.
  - T+2: RUN, flushes=0.
  - flush_count=2.
- Branch beats hazard: branch_taken=1 with lu=1 in the same cycle → pc_en=1, both flushes=1, stall_count unchanged. An lu during BR_FLUSH causes no stall.
- Back-to-back branch with FLUSH_EXTRA=3: second branch_taken at rem=2 → BR_FLUSH extended to 3 further cycles. Async reset mid-flush → busy=0 immediately, counters=0.
- Saturation (macro on, CNT_W=4): 20 consecutive lu cycles → stall_count holds 15. With the macro off → counters read 0 throughout.
